// File: rtl/rom_chk_pkg.sv
// Shared types and helpers for the ROM sweep checker.
// Holds the FSM state type, the read-latency ceiling and the saturating
// increment used by the mismatch counter.
package rom_chk_pkg;

   // Deepest ROM read latency the tag pipe is expected to cover
   localparam int RD_LAT_MAX = 8;
   // Width of the drain countdown, large enough to hold RD_LAT_MAX-1
   localparam int LAT_CNT_W  = $clog2(RD_LAT_MAX) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } rom_chk_state_t;

   // Increment that sticks at max_val instead of wrapping
   function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                           input logic [31:0] max_val);
      return (val >= max_val) ? val : val + 32'd1;
   endfunction

endpackage

// File: rtl/rom_chk_tag_pipe.sv
// Address tag delay line for the ROM sweep checker.
// Each issued address travels with a valid bit through RD_LAT stages so it
// emerges in the same cycle as the ROM read data it produced.
module rom_chk_tag_pipe #(
   parameter int ADDR_W = 9,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tag_vld,
   input  logic [ADDR_W-1:0] tag_addr,
   output logic              emerge_vld,
   output logic [ADDR_W-1:0] emerge_addr
);

   logic              vld_p  [RD_LAT];
   logic [ADDR_W-1:0] addr_p [RD_LAT];

   // Shift the valid/address pair one stage per cycle; reset empties the line
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < RD_LAT; i++) begin
            vld_p[i]  <= 1'b0;
            addr_p[i] <= '0;
         end
      end else begin
         vld_p[0]  <= tag_vld;
         addr_p[0] <= tag_addr;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_p[i]  <= vld_p[i-1];
            addr_p[i] <= addr_p[i-1];
         end
      end
   end

   assign emerge_vld  = vld_p[RD_LAT-1];
   assign emerge_addr = addr_p[RD_LAT-1];

endmodule

// File: rtl/rom_sweep_checker.sv
// ROM pair sweep checker: walks every address of a golden and a netlist ROM,
// compares the read words after RD_LAT cycles and reports a saturating
// mismatch count, the first failing address and a pass flag.
// Optional macro ROM_SWEEP_DIFF_MASK_EN builds the per-bit difference
// accumulator behind diff_mask; without it diff_mask is tied to zero.
module rom_sweep_checker
   import rom_chk_pkg::*;
#(
   parameter int ADDR_W = 9,
   parameter int DEPTH  = 512,
   parameter int DATA_W = 8,
   parameter int RD_LAT = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data_golden,
   input  logic [DATA_W-1:0] data_netlist,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [CNT_W-1:0]  mismatch_count,
   output logic              first_fail_valid,
   output logic [ADDR_W-1:0] first_fail_addr,
   output logic [DATA_W-1:0] diff_mask
);

   localparam logic [ADDR_W-1:0]    LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0]     CNT_MAX   = '1;
   localparam logic [LAT_CNT_W-1:0] DRAIN_LD  = LAT_CNT_W'(RD_LAT - 1);

   rom_chk_state_t       state;
   logic [LAT_CNT_W-1:0] drain_cnt;
   logic                 accept;
   logic                 last_drain;
   logic                 issue_vld;
   logic                 cmp_vld;
   logic [ADDR_W-1:0]    cmp_addr;
   logic                 miss;
   logic [CNT_W-1:0]     cnt_upd;

   assign accept     = (state == IDLE) && start;
   assign last_drain = (state == DRAIN) && (drain_cnt == '0);
   assign issue_vld  = (state == SWEEP);
   assign busy       = (state == SWEEP) || (state == DRAIN);
   assign done       = (state == DONE);

   rom_chk_tag_pipe #(
      .ADDR_W (ADDR_W),
      .RD_LAT (RD_LAT)
   ) u_tag_pipe (
      .clk         (clk),
      .rst         (rst),
      .tag_vld     (issue_vld),
      .tag_addr    (addr),
      .emerge_vld  (cmp_vld),
      .emerge_addr (cmp_addr)
   );

   // A tag emerging from the delay line lines up with that address's data
   assign miss    = cmp_vld && (data_golden != data_netlist);
   assign cnt_upd = miss ? CNT_W'(sat_inc(32'(mismatch_count), 32'(CNT_MAX)))
                         : mismatch_count;

   // Sequencer: walk the address range, let the last reads drain, pulse done
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         addr      <= '0;
         drain_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state <= SWEEP;
                  addr  <= '0;
               end
            end
            SWEEP: begin
               if (addr == LAST_ADDR) begin
                  state     <= DRAIN;
                  drain_cnt <= DRAIN_LD;
               end else begin
                  addr <= addr + ADDR_W'(1);
               end
            end
            DRAIN: begin
               if (drain_cnt == '0) state <= DONE;
               else                 drain_cnt <= drain_cnt - LAT_CNT_W'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Result registers: cleared when a sweep is accepted, updated per compare;
   // pass is settled on the edge that enters DONE so it is valid with done
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mismatch_count   <= '0;
         first_fail_valid <= 1'b0;
         first_fail_addr  <= '0;
         pass             <= 1'b0;
      end else if (accept) begin
         mismatch_count   <= '0;
         first_fail_valid <= 1'b0;
         first_fail_addr  <= '0;
         pass             <= 1'b0;
      end else begin
         mismatch_count <= cnt_upd;
         if (miss && !first_fail_valid) begin
            first_fail_valid <= 1'b1;
            first_fail_addr  <= cmp_addr;
         end
         if (last_drain) pass <= (cnt_upd == '0);
      end
   end

`ifdef ROM_SWEEP_DIFF_MASK_EN
   logic [DATA_W-1:0] diff_acc;

   // Collect every data bit that has ever differed during this sweep
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         diff_acc <= '0;
      else if (accept) diff_acc <= '0;
      else if (cmp_vld) diff_acc <= diff_acc | (data_golden ^ data_netlist);
   end

   assign diff_mask = diff_acc;
`else
   assign diff_mask = '0;
`endif

endmodule

// File: tb/tb_rom_sweep_checker.sv
// Self-checking bench for rom_sweep_checker: three instances (latency 1,
// latency 3, 4-bit counter) share clock, reset and start and read the same
// golden/netlist ROM images through latency-matched read models.
module tb_rom_sweep_checker;

   localparam int AW = 9;
   localparam int DW = 8;
   localparam int DEP = 512;

   logic clk = 1'b0;
   logic rst;
   logic start;

   logic [DW-1:0] golden [DEP];
   logic [DW-1:0] netl   [DEP];

   logic [AW-1:0] a  [3];
   logic          b  [3];
   logic          d  [3];
   logic          p  [3];
   logic          fv [3];
   logic [AW-1:0] fa [3];
   logic [DW-1:0] dm [3];
   logic [15:0]   mc0, mc1;
   logic [3:0]    mc2;

   logic [DW-1:0] g0, n0, g2, n2;
   logic [DW-1:0] gq [3];
   logic [DW-1:0] nq [3];

   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   // ROM read models: one registered stage, or three for the latency-3 instance
   always @(posedge clk) begin
      g0 <= golden[a[0]];
      n0 <= netl[a[0]];
      g2 <= golden[a[2]];
      n2 <= netl[a[2]];
      gq[0] <= golden[a[1]];
      nq[0] <= netl[a[1]];
      for (int i = 1; i < 3; i++) begin
         gq[i] <= gq[i-1];
         nq[i] <= nq[i-1];
      end
   end

   rom_sweep_checker #(.ADDR_W(AW), .DEPTH(DEP), .DATA_W(DW), .RD_LAT(1), .CNT_W(16)) u0 (
      .clk(clk), .rst(rst), .start(start), .addr(a[0]),
      .data_golden(g0), .data_netlist(n0),
      .busy(b[0]), .done(d[0]), .pass(p[0]), .mismatch_count(mc0),
      .first_fail_valid(fv[0]), .first_fail_addr(fa[0]), .diff_mask(dm[0]));

   rom_sweep_checker #(.ADDR_W(AW), .DEPTH(DEP), .DATA_W(DW), .RD_LAT(3), .CNT_W(16)) u1 (
      .clk(clk), .rst(rst), .start(start), .addr(a[1]),
      .data_golden(gq[2]), .data_netlist(nq[2]),
      .busy(b[1]), .done(d[1]), .pass(p[1]), .mismatch_count(mc1),
      .first_fail_valid(fv[1]), .first_fail_addr(fa[1]), .diff_mask(dm[1]));

   rom_sweep_checker #(.ADDR_W(AW), .DEPTH(DEP), .DATA_W(DW), .RD_LAT(1), .CNT_W(4)) u2 (
      .clk(clk), .rst(rst), .start(start), .addr(a[2]),
      .data_golden(g2), .data_netlist(n2),
      .busy(b[2]), .done(d[2]), .pass(p[2]), .mismatch_count(mc2),
      .first_fail_valid(fv[2]), .first_fail_addr(fa[2]), .diff_mask(dm[2]));

   task automatic chk(input string name, input longint got, input longint exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, got, got, exp, exp);
   endtask

   function automatic longint cnt_of(input int k);
      if (k == 0) return longint'(mc0);
      if (k == 1) return longint'(mc1);
      return longint'(mc2);
   endfunction

   function automatic logic [DW-1:0] diff_exp(input logic [DW-1:0] v);
`ifdef ROM_SWEEP_DIFF_MASK_EN
      return v;
`else
      return '0;
`endif
   endfunction

   // Reference: derive expected results straight from the two ROM images
   task automatic model(output int e_cnt, output bit e_ffv, output int e_ffa,
                        output logic [DW-1:0] e_diff);
      e_cnt = 0; e_ffv = 0; e_ffa = 0; e_diff = '0;
      for (int i = 0; i < DEP; i++) begin
         if (golden[i] != netl[i]) begin
            if (!e_ffv) e_ffa = i;
            e_ffv = 1;
            e_cnt++;
            e_diff |= golden[i] ^ netl[i];
         end
      end
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, " addr"},  a[0], 0);
      chk({tag, " busy"},  b[0], 0);
      chk({tag, " done"},  d[0], 0);
      chk({tag, " pass"},  p[0], 0);
      chk({tag, " count"}, mc0, 0);
      chk({tag, " ffv"},   fv[0], 0);
      chk({tag, " ffa"},   fa[0], 0);
      chk({tag, " diff"},  dm[0], 0);
      chk({tag, " busy_u1"}, b[1], 0);
      chk({tag, " busy_u2"}, b[2], 0);
   endtask

   // One start pulse, then watch all three instances to completion
   task automatic run_sweep(input string tag, input int e_cnt, input bit e_ffv,
                            input int e_ffa, input logic [DW-1:0] e_diff);
      int busy_n [3];
      int done_c [3];
      int done_n [3];
      int lat [3];
      int c;
      bit done_busy_ok;
      bit addr_ok;
      int cap;
      lat = '{1, 3, 1};
      for (int k = 0; k < 3; k++) begin
         busy_n[k] = 0; done_c[k] = 0; done_n[k] = 0;
      end
      done_busy_ok = 1;
      addr_ok = 1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      c = 1;
      while (c <= 700 && (done_n[0] == 0 || done_n[1] == 0 || done_n[2] == 0)) begin
         for (int k = 0; k < 3; k++) begin
            if (b[k]) busy_n[k]++;
            if (d[k]) begin
               done_n[k]++;
               if (done_c[k] == 0) done_c[k] = c;
               if (b[k]) done_busy_ok = 0;
            end
         end
         if (c <= DEP && a[0] != AW'(c - 1)) addr_ok = 0;
         @(posedge clk); #1;
         c++;
      end
      chk($sformatf("%s addr_seq", tag), addr_ok, 1);
      chk($sformatf("%s done_without_busy", tag), done_busy_ok, 1);
      for (int k = 0; k < 3; k++) begin
         cap = (k == 2 && e_cnt > 15) ? 15 : e_cnt;
         chk($sformatf("%s u%0d busy_len", tag, k), busy_n[k], DEP + lat[k]);
         chk($sformatf("%s u%0d done_cycle", tag, k), done_c[k], DEP + lat[k] + 1);
         chk($sformatf("%s u%0d done_pulses", tag, k), done_n[k], 1);
         chk($sformatf("%s u%0d count", tag, k), cnt_of(k), cap);
         chk($sformatf("%s u%0d pass", tag, k), p[k], (e_cnt == 0) ? 1 : 0);
         chk($sformatf("%s u%0d ffv", tag, k), fv[k], e_ffv);
         if (e_ffv) chk($sformatf("%s u%0d ffa", tag, k), fa[k], e_ffa);
         chk($sformatf("%s u%0d diff", tag, k), dm[k], diff_exp(e_diff));
      end
   endtask

   typedef struct {
      int            n;      // -1: every word inverted
      int            a0;
      int            a1;
      logic [DW-1:0] gv;
      logic [DW-1:0] nv;
      int            e_cnt;
      bit            e_ffv;
      int            e_ffa;
      logic [DW-1:0] e_diff;
   } vec_t;

   vec_t tbl [5];

   initial begin
      int e_cnt;
      bit e_ffv;
      int e_ffa;
      logic [DW-1:0] e_diff;
      int nerr;
      int ra;
      int nd;
      bit seen;

      tbl[0] = '{0,   0,   0, 8'h00, 8'h00,   0, 1'b0,   0, 8'h00};
      tbl[1] = '{1,  37,   0, 8'h5A, 8'hA5,   1, 1'b1,  37, 8'hFF};
      tbl[2] = '{2, 100, 300, 8'h33, 8'h32,   2, 1'b1, 100, 8'h01};
      tbl[3] = '{2, 511,   0, 8'h80, 8'h00,   2, 1'b1,   0, 8'h80};
      tbl[4] = '{-1,  0,   0, 8'h00, 8'h00, 512, 1'b1,   0, 8'hFF};

      rst = 1'b1;
      start = 1'b0;
      for (int i = 0; i < DEP; i++) begin
         golden[i] = DW'($urandom);
         netl[i] = golden[i];
      end
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outs("reset");
      @(negedge clk);
      rst = 1'b0;

      // Table-driven directed sweeps
      for (int t = 0; t < 5; t++) begin
         for (int i = 0; i < DEP; i++) netl[i] = golden[i];
         if (tbl[t].n < 0) begin
            for (int i = 0; i < DEP; i++) netl[i] = ~golden[i];
         end else begin
            if (tbl[t].n >= 1) begin
               golden[tbl[t].a0] = tbl[t].gv;
               netl[tbl[t].a0] = tbl[t].nv;
            end
            if (tbl[t].n >= 2) begin
               golden[tbl[t].a1] = tbl[t].gv;
               netl[tbl[t].a1] = tbl[t].nv;
            end
         end
         run_sweep($sformatf("vec%0d", t), tbl[t].e_cnt, tbl[t].e_ffv,
                   tbl[t].e_ffa, tbl[t].e_diff);
      end

      // Randomized corruption against the reference model
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < DEP; i++) netl[i] = golden[i];
         nerr = $urandom_range(0, 6);
         for (int j = 0; j < nerr; j++) begin
            ra = $urandom_range(0, DEP - 1);
            netl[ra] = golden[ra] ^ DW'($urandom_range(1, 255));
         end
         model(e_cnt, e_ffv, e_ffa, e_diff);
         run_sweep($sformatf("rand%0d", r), e_cnt, e_ffv, e_ffa, e_diff);
      end

      // Reset in the middle of a sweep, then a clean restart
      for (int i = 0; i < DEP; i++) netl[i] = golden[i];
      netl[5] = golden[5] ^ 8'h01;
      @(posedge clk);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 300 && a[0] != AW'(100); i++) begin
         @(posedge clk); #1;
      end
      chk("midrst pre addr", a[0], 100);
      chk("midrst pre count", mc0, 1);
      #2;
      rst = 1'b1;
      #1;
      chk_reset_outs("midrst");
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < DEP; i++) netl[i] = golden[i];
      netl[200] = golden[200] ^ 8'h10;
      run_sweep("after_rst", 1, 1'b1, 200, 8'h10);

      // start held high: one sweep, idle gap, then the next sweep begins
      for (int i = 0; i < DEP; i++) netl[i] = golden[i];
      @(posedge clk);
      @(negedge clk);
      start = 1'b1;
      nd = 0;
      seen = 0;
      for (int i = 0; i < 700 && !seen; i++) begin
         @(posedge clk); #1;
         if (d[0]) begin
            nd++;
            seen = 1;
         end
      end
      chk("hold done seen", nd, 1);
      chk("hold pass", p[0], 1);
      @(posedge clk); #1;
      chk("hold gap busy", b[0], 0);
      chk("hold gap done", d[0], 0);
      @(posedge clk); #1;
      chk("hold restart busy", b[0], 1);
      chk("hold restart addr", a[0], 0);
      chk("hold restart pass cleared", p[0], 0);
      start = 1'b0;
      #2;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/rom_sweep_checker.md
# rom_sweep_checker

Synthesizable, parametrised successor to the post-route ROM comparison bench. It sweeps every address of a ROM pair (golden model and post-route netlist) and compares the two read data words with a configurable read latency. It accumulates a saturating mismatch count and captures the first failing address. It sits beside the two ROM instances in bench or on-chip self-test wrappers and reports pass/fail through a start/done handshake.

## Interface
- `ADDR_W`, default 9: address width of both ROMs.
- `DEPTH`, default 512: number of words swept, 1..2^ADDR_W.
- `DATA_W`, default 8: read data width.
- `RD_LAT`, default 1: ROM read latency in cycles, 1..8.
- `CNT_W`, default 16: mismatch counter width.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset; asynchronous, active-high.
- `start`  in  1: sweep request; sampled only when not busy.
- `addr`  out  ADDR_W: address driven to both ROMs.
- `data_golden`  in  DATA_W: golden ROM read data.
- `data_netlist`  in  DATA_W: netlist ROM read data.
- `busy`  out  1: high from the first issued address through the last compare.
- `done`  out  1: one-cycle pulse when the sweep completes.
- `pass`  out  1: equals (mismatch_count==0); valid from done until the next start.
- `mismatch_count`  out  CNT_W: saturating count of mismatching words.
- `first_fail_valid`  out  1: at least one mismatch seen this sweep.
- `first_fail_addr`  out  ADDR_W: address of the first mismatch.
- `diff_mask`  out  DATA_W: OR of all golden^netlist differences (see Configuration).

## Operation
- FSM states:
  - IDLE: on `start`, go to SWEEP.
  - SWEEP: issue addresses 0..DEPTH-1, one per cycle; after DEPTH-1 is issued, go to DRAIN.
  - DRAIN: wait RD_LAT cycles, then go to DONE.
  - DONE: assert `done` for one cycle, then return to IDLE.
- On entry to SWEEP, clear `mismatch_count`, `first_fail_valid`, `first_fail_addr` and `diff_mask`.
- Address tagging: each issued address enters an RD_LAT-deep valid/address delay line. The compare happens when the tag emerges, using that tag's address.
- Compare is `data_golden != data_netlist`. On a mismatch:
  - increment the count, saturating at 2^CNT_W-1;
  - if `first_fail_valid`==0, capture the address and set `first_fail_valid`.
- `addr` holds the last issued value outside SWEEP. Its reset value is 0.
- `start` while busy, or in the DONE cycle, is ignored (no queueing).
- Reset values: `addr`=0, `busy`=0, `done`=0, `pass`=0, `mismatch_count`=0, `first_fail_valid`=0, `first_fail_addr`=0, `diff_mask`=0, state=IDLE, delay line cleared.
- Reset mid-sweep aborts immediately. There is no partial result, and a new `start` after reset restarts at address 0.
- `pass` is registered. It is updated in the DONE cycle and held until the next sweep begins, when it is cleared.

## Timing
- `start` sampled high at edge T:
  - `busy`=1 and `addr`=0 from T+1;
  - `addr`=k at T+1+k;
  - the compare for address k happens at edge T+1+k+RD_LAT.
- `busy` lasts DEPTH+RD_LAT cycles. `done` is high in cycle T+1+DEPTH+RD_LAT, with `busy`=0 in that cycle.
- Result outputs are stable when `done` is high and remain stable until the next accepted `start`.
- Back-to-back sweeps: the earliest accepted `start` is the cycle after `done`.

## Configuration
- `ROM_SWEEP_DIFF_MASK_EN`
  - Defined: `diff_mask` accumulates the bitwise OR of (golden^netlist) over every compared word, identifying which data bits ever failed.
  - Undefined: the accumulator is not built and `diff_mask` is tied to 0.

## Structure
- Package `rom_chk_pkg`:
  - state enum typedef `rom_chk_state_t` (IDLE, SWEEP, DRAIN, DONE);
  - saturating-increment function;
  - localparam for the maximum RD_LAT of 8.
- Sub-module `rom_chk_tag_pipe`: parametrised valid plus ADDR_W shift register of depth RD_LAT, with async reset.
- The top holds the FSM, address counter, compare and result registers.

## Test plan
- Identical ROMs, DEPTH=512, RD_LAT=1, `start` pulse -> `busy` for 513 cycles, one `done` pulse, `pass`=1, `mismatch_count`=0, `first_fail_valid`=0.
- Netlist word 37 corrupted (0x5A vs 0xA5) -> `mismatch_count`=1, `first_fail_addr`=37, `pass`=0; with the macro, `diff_mask`=0xFF.
- Words 100 and 300 corrupted, RD_LAT=3 -> count=2, `first_fail_addr`=100, `done` at T+1+512+3.
- All words mismatch with CNT_W=4 -> `mismatch_count` saturates at 15, `pass`=0.
- `rst` asserted while `addr`=100, then `start` -> outputs return to reset values asynchronously and the new sweep starts at `addr`=0 with fresh results.
- `start` held high for the whole sweep -> exactly one sweep completes, then a new sweep is accepted the cycle after `done`.
